muldiv_issue_ctrl: RTL and testbench

//  Decode-stage controller for the shared multi-cycle HI/LO unit (MULTU/DIVU). Issues operations to the unit,

---
 rtl/muldiv_issue_ctrl_pkg.sv | 33 +++
 rtl/muldiv_issue_ctrl_if.sv | 34 +++
 rtl/muldiv_issue_ctrl_md_lat_counter.sv | 26 ++
 rtl/muldiv_issue_ctrl.sv | 109 ++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared decode constants, FSM encoding and instruction classifier for the HI/LO issue controller.
// Optional feature macro used by this slice: MULDIV_PERF_CNT_EN (adds a stall-cycle counter).
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic is_hilo_read;
    logic is_mul;
    logic is_div;
  } md_decode_t;

  function automatic md_decode_t md_decode(input logic [5:0] opcode, input logic [5:0] funct);
    md_decode_t d;
    d = '0;
    if (opcode == OP_RTYPE) begin
      d.is_hilo_read = (funct == FN_MFHI) || (funct == FN_MFLO);
      d.is_mul       = (funct == FN_MULTU);
      d.is_div       = (funct == FN_DIVU);
    end
    return d;
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Decode-side bundle between the front end and the HI/LO issue controller.
// MULDIV_PERF_CNT_EN adds the stall_cnt signal to the bundle.
interface muldiv_issue_ctrl_if;
  import muldiv_pkg::*;

  // Handshake: there is no valid/ready pair; instr is offered whenever instr_valid=1 and flush=0,
  // and it is accepted in any cycle where pc_en=1 (pc_en=0 means hold the same instr next cycle).
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        pc_en;
  logic        nop;
  logic        md_start;
  logic        md_div;
  logic        hilo_we;
  logic        busy;
  md_state_e   fsm_state;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

`ifdef MULDIV_PERF_CNT_EN
  modport master (output instr, instr_valid, flush,
                  input  pc_en, nop, md_start, md_div, hilo_we, busy, fsm_state, stall_cnt);
  modport slave  (input  instr, instr_valid, flush,
                  output pc_en, nop, md_start, md_div, hilo_we, busy, fsm_state, stall_cnt);
`else
  modport master (output instr, instr_valid, flush,
                  input  pc_en, nop, md_start, md_div, hilo_we, busy, fsm_state);
  modport slave  (input  instr, instr_valid, flush,
                  output pc_en, nop, md_start, md_div, hilo_we, busy, fsm_state);
`endif

endinterface

// File: rtl/muldiv_issue_ctrl_md_lat_counter.sv
// Loadable down-counter tracking the remaining busy cycles of the HI/LO unit.
module md_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the shared MULTU/DIVU unit: starts ops, holds HI/LO users in decode, writes HI/LO.
// Define MULDIV_PERF_CNT_EN to add the stall_cnt performance counter.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_issue_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic             md_start_q, md_start_d;
  logic             md_div_q, md_div_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value, cnt_value;
  md_decode_t       dec;
  logic             qualified, is_op, hilo_user, stall;
  logic             unused_instr_bits;

  // Only opcode and funct matter for HI/LO tracking.
  assign dec               = md_decode(bus.instr[31:26], bus.instr[5:0]);
  assign unused_instr_bits = ^bus.instr[25:6];
  assign qualified         = bus.instr_valid & ~bus.flush;
  assign is_op             = dec.is_mul | dec.is_div;
  assign hilo_user         = is_op | dec.is_hilo_read;

  md_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      md_start_q <= 1'b0;
      md_div_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_start_q <= md_start_d;
      md_div_q   <= md_div_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    md_start_d     = 1'b0;
    md_div_d       = md_div_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The issuing instruction itself never stalls; the unit starts next cycle.
        if (qualified && is_op) begin
          state_d        = ST_BUSY;
          md_start_d     = 1'b1;
          md_div_d       = dec.is_div;
          cnt_load       = 1'b1;
          cnt_load_value = dec.is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completion cycle still counts as busy, so a stalled consumer reads fresh HI/LO one cycle later.
  assign stall         = (state_q == ST_BUSY) & qualified & hilo_user;
  assign bus.pc_en     = ~stall;
  assign bus.nop       = stall;
  assign bus.md_start  = md_start_q;
  assign bus.md_div    = md_div_q;
  assign bus.hilo_we   = (state_q == ST_BUSY) & cnt_zero;
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.fsm_state = state_q;

`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl: directed timing scenarios followed by random decode traffic.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 32;
  localparam int DIV_LAT = 34;
  localparam int W       = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_issue_ctrl_if bus ();

  muldiv_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Each entry: {mask, expected} over {pc_en, nop, md_start, md_div, hilo_we, busy, state_is_busy}.
  logic [2*W-1:0] exp_q[$];
  logic [31:0]    cnt_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: the unit is busy over an interval of absolute cycle numbers.
  int cyc         = 0;
  int b_start     = -100;
  int b_end       = -100;
  bit op_div      = 1'b0;
  int stall_total = 0;
  bit sb_on       = 1'b0;

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'd0;
    w[5:0]   = fn;
    return w;
  endfunction

  function automatic logic [31:0] other_instr(input int sel);
    logic [31:0] w;
    w = $urandom;
    case (sel)
      0: begin w[31:26] = 6'd0;  w[5:0] = 6'd32; end // ADD
      1: w[31:26] = 6'd35;                            // LW
      2: w[31:26] = 6'd4;                             // BEQ
      default: begin w[31:26] = 6'd9; w[5:0] = 6'd25; end // non-R-type with MULTU funct bits
    endcase
    return w;
  endfunction

  task automatic step(input logic [31:0] ins, input logic v, input logic f, input logic r,
                      output bit stalled);
    bit busy_e, start_e, hilo_e, qual, rd, mul, dv, stall_e;
    logic [W-1:0] e, m;
    @(posedge clk);
    #1;
    bus.instr       = ins;
    bus.instr_valid = v;
    bus.flush       = f;
    reset           = r;
    busy_e  = (cyc >= b_start) && (cyc <= b_end);
    start_e = (cyc == b_start);
    hilo_e  = busy_e && (cyc == b_end);
    qual    = v && !f;
    rd      = (ins[31:26] == 6'd0) && (ins[5:0] == 6'd16 || ins[5:0] == 6'd18);
    mul     = (ins[31:26] == 6'd0) && (ins[5:0] == 6'd25);
    dv      = (ins[31:26] == 6'd0) && (ins[5:0] == 6'd27);
    stall_e = busy_e && qual && (rd || mul || dv);
    e = {!stall_e, stall_e, start_e, op_div, hilo_e, busy_e, busy_e};
    m = {1'b1, 1'b1, 1'b1, start_e, 1'b1, 1'b1, 1'b1};
    if (sb_on) begin
      exp_q.push_back({m, e});
      cnt_q.push_back(32'(stall_total));
    end
    if (r) begin
      b_start = -100;
      b_end   = -100;
      stall_total = 0;
    end else begin
      if (stall_e) stall_total++;
      if (!busy_e && qual && (mul || dv)) begin
        b_start = cyc + 1;
        b_end   = cyc + (dv ? DIV_LAT : MUL_LAT);
        op_div  = dv;
      end
    end
    cyc++;
    stalled = stall_e;
  endtask

  // Present an instruction to decode and hold it there while the model says decode is stalled.
  task automatic issue(input logic [31:0] ins, input logic v, input logic f);
    bit s;
    int guard;
    guard = 0;
    do begin
      step(ins, v, f, 1'b0, s);
      guard++;
    end while (s && guard < 200);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(other_instr(0), 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [2*W-1:0] ent;
    logic [W-1:0]   act;
    logic [31:0]    ec;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        ec  = cnt_q.pop_front();
        act = {bus.pc_en, bus.nop, bus.md_start, bus.md_div, bus.hilo_we, bus.busy,
               bus.fsm_state == ST_BUSY};
        checks++;
        if ((act & ent[2*W-1:W]) !== (ent[W-1:0] & ent[2*W-1:W])) begin
          failures++;
          $display("FAIL outputs t=%0t {pc_en,nop,md_start,md_div,hilo_we,busy,st} got=%b want=%b mask=%b",
                   $time, act, ent[W-1:0], ent[2*W-1:W]);
        end
`ifdef MULDIV_PERF_CNT_EN
        checks++;
        if (bus.stall_cnt !== ec) begin
          failures++;
          $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, bus.stall_cnt, ec);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    bit s;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    reset           = 1'b1;
    step('0, 1'b0, 1'b0, 1'b1, s);
    step('0, 1'b0, 1'b0, 1'b1, s);
    sb_on = 1'b1;

    // Reset state, single MULTU, then DIVU followed by a consumer.
    idle(2);
    issue(rtype(FN_MULTU), 1'b1, 1'b0);
    idle(40);
    issue(rtype(FN_DIVU), 1'b1, 1'b0);
    issue(rtype(FN_MFLO), 1'b1, 1'b0);
    idle(40);
    // Back-to-back producers.
    issue(rtype(FN_DIVU), 1'b1, 1'b0);
    issue(rtype(FN_MULTU), 1'b1, 1'b0);
    idle(40);
    // Unrelated traffic runs while the unit is busy.
    issue(rtype(FN_MULTU), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) issue(other_instr(int'($urandom_range(0, 3))), 1'b1, 1'b0);
    idle(3);
    // Unqualified consumers, then reset in the middle of an op.
    issue(rtype(FN_DIVU), 1'b1, 1'b0);
    issue(rtype(FN_MFHI), 1'b1, 1'b1);
    issue(rtype(FN_MFHI), 1'b0, 1'b0);
    idle(7);
    step('0, 1'b0, 1'b0, 1'b1, s);
    idle(40);

    // Random decode traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ins;
      int sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: ins = rtype(FN_MFHI);
        1: ins = rtype(FN_MFLO);
        2: ins = rtype(FN_MULTU);
        3: ins = rtype(FN_DIVU);
        default: ins = other_instr(sel - 4);
      endcase
      if ($urandom_range(0, 199) == 0) begin
        step('0, 1'b0, 1'b0, 1'b1, s);
      end else begin
        issue(ins, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
      end
    end
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
